leaf_out_arbiter: RTL and testbench

- Schedules a leaf's NUM_OUT_PORTS user output streams onto the single 49-bit leaf-to-BFT packet link.
- Forms packets from per-port routing config and per-port sequence addresses.
- Enforces per-port freespace credit, which is replenished by updates from the receiving leaf.
- Sits between the user kernel's AXI-stream-style outputs and the leaf interface's outbound packet register, in the 400 MHz domain.

---
 rtl/leaf_pkt_pkg.sv | 31 +++
 rtl/leaf_rr_arbiter.sv | 37 +++
 rtl/leaf_out_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Shared leaf packet layout, arbiter state encodings and packet assembly.
// Fields, high to low: valid, dest leaf, dest port, sequence address, payload.
package leaf_pkt_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 43;
  localparam int PORT_LSB  = 39;
  localparam int ADDR_LSB  = 32;

  localparam logic [1:0] ST_CONFIG = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  function automatic logic [PKT_W-1:0] make_pkt(
    input logic [4:0]  leaf,
    input logic [3:0]  port,
    input logic [6:0]  addr,
    input logic [31:0] data
  );
    logic [PKT_W-1:0] p;
    p                   = '0;
    p[VALID_BIT]        = 1'b1;
    p[LEAF_LSB +: 5]    = leaf;
    p[PORT_LSB +: 4]    = port;
    p[ADDR_LSB +: 7]    = addr;
    p[31:0]             = data;
    return p;
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr (mod N) wins, and the
// pointer advances to the slot after the winner.
module leaf_rr_arbiter #(
  parameter int N        = 4,
  parameter int PTR_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [PTR_BITS-1:0] next_ptr,
  output logic                any_grant
);

  localparam logic [PTR_BITS:0] N_W = (PTR_BITS+1)'(N);

  logic [PTR_BITS:0]   slot;
  logic [PTR_BITS-1:0] idx;

  always_comb begin
    grant     = '0;
    next_ptr  = ptr;
    any_grant = 1'b0;
    slot      = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, ptr} + (PTR_BITS+1)'(i);
      if (slot >= N_W) slot = slot - N_W;
      idx = slot[PTR_BITS-1:0];
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = ((slot + 1'b1) == N_W) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Schedules per-port user streams onto the leaf-to-BFT packet link with credits.
// Optional per-port credit-stall counters: LEAF_OUT_ARBITER_PERF_CNT_EN.
//
// state  | meaning
// CONFIG | routing config writable, no arbitration
// RUN    | round-robin arbitration of credited, valid ports
// DRAIN  | no new grants; back to CONFIG once dout_pkt is empty
module leaf_out_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int NUM_OUT_PORTS = 4,
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int INIT_CREDIT   = 128
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                stop,
  output logic [1:0]                          state_o,
  input  logic                                cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]            cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]            cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]            cfg_dport,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]            vld_user,
  output logic [NUM_OUT_PORTS-1:0]            ack_user,
  input  logic                                upd_vld,
  input  logic [NUM_PORT_BITS-1:0]            upd_port,
  input  logic [NUM_ADDR_BITS:0]              upd_amount,
  input  logic                                out_stall,
  output logic [PACKET_BITS-1:0]              dout_pkt,
  output logic [31:0]                         dbg_stall_cnt
);

  localparam int IDX_BITS = $clog2(NUM_OUT_PORTS);
  localparam int CW       = NUM_ADDR_BITS + 1;
  localparam logic [NUM_PORT_BITS:0] N_PORTS = (NUM_PORT_BITS+1)'(NUM_OUT_PORTS);
  localparam logic [CW:0]            INIT_W  = (CW+1)'(INIT_CREDIT);

  logic [1:0]               state;
  logic [IDX_BITS-1:0]      rr_ptr, rr_next;
  logic [NUM_LEAF_BITS-1:0] leaf_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit  [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];
  logic [CW:0]              credit_sum [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr    [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] req, grant;
  logic                     grant_any, grant_ok, do_grant, xfer, start_load;
  logic                     cfg_ok, upd_ok;
  logic [NUM_LEAF_BITS-1:0] sel_leaf;
  logic [NUM_PORT_BITS-1:0] sel_dport;
  logic [NUM_ADDR_BITS-1:0] sel_addr;
  logic [PAYLOAD_BITS-1:0]  sel_data;

  assign state_o    = state;
  assign cfg_ok     = {1'b0, cfg_port} < N_PORTS;
  assign upd_ok     = upd_vld && ({1'b0, upd_port} < N_PORTS);
  // stop beats start, so a simultaneous pair leaves CONFIG untouched
  assign start_load = (state == ST_CONFIG) && start && !stop;
  assign xfer       = dout_pkt[VALID_BIT] && !out_stall;
  assign grant_ok   = !dout_pkt[VALID_BIT] || !out_stall;

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      req[i] = (state == ST_RUN) && vld_user[i] && (credit[i] != '0);
  end

  leaf_rr_arbiter #(.N(NUM_OUT_PORTS), .PTR_BITS(IDX_BITS)) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .next_ptr  (rr_next),
    .any_grant (grant_any)
  );

  assign ack_user = grant_ok ? grant : '0;
  assign do_grant = grant_ok && grant_any;

  always_comb begin
    sel_leaf  = '0;
    sel_dport = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        sel_leaf  = sel_leaf  | leaf_q[i];
        sel_dport = sel_dport | dport_q[i];
        sel_addr  = sel_addr  | addr[i];
        sel_data  = sel_data  | din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Returned credit and a same-cycle grant combine before saturation.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = {1'b0, credit[i]} - {{CW{1'b0}}, ack_user[i]}
                    + ((upd_ok && upd_port[IDX_BITS-1:0] == IDX_BITS'(i))
                       ? {1'b0, upd_amount} : '0);
      credit_nxt[i] = (credit_sum[i] > INIT_W) ? INIT_W[CW-1:0] : credit_sum[i][CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CONFIG;
      dout_pkt <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]  <= '0;
        dport_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_CONFIG: if (start_load) state <= ST_RUN;
        ST_RUN:    if (stop) state <= ST_DRAIN;
        ST_DRAIN:  if (!dout_pkt[VALID_BIT]) state <= ST_CONFIG;
        default:   state <= ST_CONFIG;
      endcase
      if (state == ST_CONFIG && cfg_wr && cfg_ok) begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
          if (cfg_port[IDX_BITS-1:0] == IDX_BITS'(i)) begin
            leaf_q[i]  <= cfg_leaf;
            dport_q[i] <= cfg_dport;
          end
        end
      end
      if (do_grant) begin
        dout_pkt <= make_pkt(sel_leaf, sel_dport, sel_addr, sel_data);
        rr_ptr   <= rr_next;
      end else if (xfer) begin
        dout_pkt[VALID_BIT] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= '0;
        addr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (start_load) begin
          credit[i] <= INIT_W[CW-1:0];
          addr[i]   <= '0;
        end else begin
          credit[i] <= credit_nxt[i];
          if (ack_user[i]) addr[i] <= addr[i] + 1'b1;
        end
      end
    end
  end

`ifdef LEAF_OUT_ARBITER_PERF_CNT_EN
  logic [31:0] stall_cnt [NUM_OUT_PORTS];
  logic [31:0] dbg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (start_load)
          stall_cnt[i] <= '0;
        else if (state == ST_RUN && vld_user[i] && credit[i] == '0 && stall_cnt[i] != '1)
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
      dbg_q <= cfg_ok ? stall_cnt[cfg_port[IDX_BITS-1:0]] : '0;
    end
  end

  assign dbg_stall_cnt = dbg_q;
`else
  assign dbg_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: vector table plus hand-written
// sequences for drain, credit exhaustion/refill, saturation and async reset.
module tb_leaf_out_arbiter;

  localparam logic [31:0] D0 = 32'hA5A5_0001;
  localparam logic [31:0] D1 = 32'hB1B1_0002;
  localparam logic [31:0] D2 = 32'hC2C2_0003;
  localparam logic [31:0] D3 = 32'hD3D3_0004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [3:0]  cfg_port = '0, cfg_dport = '0;
  logic [4:0]  cfg_leaf = '0;
  logic [127:0] din_user;
  logic [3:0]  vld_user = '0;
  logic [3:0]  ack_user;
  logic        upd_vld = 1'b0;
  logic [3:0]  upd_port = '0;
  logic [7:0]  upd_amount = '0;
  logic        out_stall = 1'b0;
  logic [48:0] dout_pkt;
  logic [1:0]  state_o;
  logic [31:0] dbg_stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  vld;
    logic        stall;
    logic [3:0]  ack;
    logic [48:0] pkt;
  } vec_t;

  vec_t tbl [19];

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stop          (stop),
    .state_o       (state_o),
    .cfg_wr        (cfg_wr),
    .cfg_port      (cfg_port),
    .cfg_leaf      (cfg_leaf),
    .cfg_dport     (cfg_dport),
    .din_user      (din_user),
    .vld_user      (vld_user),
    .ack_user      (ack_user),
    .upd_vld       (upd_vld),
    .upd_port      (upd_port),
    .upd_amount    (upd_amount),
    .out_stall     (out_stall),
    .dout_pkt      (dout_pkt),
    .dbg_stall_cnt (dbg_stall_cnt)
  );

  function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] p, input logic [4:0] l, input logic [3:0] d);
    cfg_wr = 1'b1; cfg_port = p; cfg_leaf = l; cfg_dport = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  initial begin
    int n;
    int aerr;
    logic got;

    din_user = {D3, D2, D1, D0};

    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, pk(5'd3, 4'd2, 7'd0, D0)};
    tbl[1]  = '{4'b0001, 1'b0, 4'b0001, pk(5'd3, 4'd2, 7'd1, D0)};
    tbl[2]  = '{4'b0001, 1'b0, 4'b0001, pk(5'd3, 4'd2, 7'd2, D0)};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0000, 49'd0};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0010, pk(5'd5, 4'd7, 7'd0, D1)};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0100, pk(5'd9, 4'd1, 7'd0, D2)};
    tbl[6]  = '{4'b1111, 1'b0, 4'b1000, pk(5'd31, 4'd15, 7'd0, D3)};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0001, pk(5'd3, 4'd2, 7'd3, D0)};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0010, pk(5'd5, 4'd7, 7'd1, D1)};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0000, pk(5'd5, 4'd7, 7'd1, D1)};
    tbl[10] = '{4'b1111, 1'b1, 4'b0000, pk(5'd5, 4'd7, 7'd1, D1)};
    tbl[11] = '{4'b1111, 1'b1, 4'b0000, pk(5'd5, 4'd7, 7'd1, D1)};
    tbl[12] = '{4'b1111, 1'b1, 4'b0000, pk(5'd5, 4'd7, 7'd1, D1)};
    tbl[13] = '{4'b1111, 1'b0, 4'b0100, pk(5'd9, 4'd1, 7'd1, D2)};
    tbl[14] = '{4'b1010, 1'b0, 4'b1000, pk(5'd31, 4'd15, 7'd1, D3)};
    tbl[15] = '{4'b1010, 1'b0, 4'b0010, pk(5'd5, 4'd7, 7'd2, D1)};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, pk(5'd5, 4'd7, 7'd2, D1)};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 49'd0};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 49'd0};

    // reset state, with requests already asserted
    vld_user = 4'b1111;
    #3;
    chk("reset_pkt", 64'(dout_pkt), 64'd0);
    chk("reset_state", 64'(state_o), 64'd0);
    chk("reset_ack", 64'(ack_user), 64'd0);
    tick();
    reset_n = 1'b1;
    vld_user = 4'b0000;
    tick();

    cfg(4'd0, 5'd3, 4'd2);
    cfg(4'd1, 5'd5, 4'd7);
    cfg(4'd2, 5'd9, 4'd1);
    cfg(4'd3, 5'd31, 4'd15);
    cfg(4'd4, 5'd7, 4'd7);
    chk("cfg_state", 64'(state_o), 64'd0);

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_in_config", 64'(state_o), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_run", 64'(state_o), 64'd1);

    for (int r = 0; r < 19; r++) begin
      vld_user  = tbl[r].vld;
      out_stall = tbl[r].stall;
      #1;
      chk($sformatf("vec%0d_ack", r), 64'(ack_user), 64'(tbl[r].ack));
      tick();
      if (tbl[r].pkt[48])
        chk($sformatf("vec%0d_pkt", r), 64'(dout_pkt), 64'(tbl[r].pkt));
      else
        chk($sformatf("vec%0d_valid", r), 64'(dout_pkt[48]), 64'd0);
    end
    out_stall = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run", 64'(state_o), 64'd1);

    // stop with all ports requesting; config write in RUN must not land
    vld_user = 4'b1111;
    stop = 1'b1;
    cfg_wr = 1'b1; cfg_port = 4'd0; cfg_leaf = 5'd31; cfg_dport = 4'd15;
    #1;
    chk("stop_cycle_ack", 64'(ack_user), 64'b0100);
    tick();
    stop = 1'b0; cfg_wr = 1'b0;
    chk("drain_state", 64'(state_o), 64'd2);
    chk("drain_last_pkt", 64'(dout_pkt), 64'(pk(5'd9, 4'd1, 7'd2, D2)));
    #1;
    chk("drain_ack", 64'(ack_user), 64'd0);
    tick();
    chk("drain_state2", 64'(state_o), 64'd2);
    chk("drain_empty", 64'(dout_pkt[48]), 64'd0);
    chk("drain_ack2", 64'(ack_user), 64'd0);
    tick();
    chk("drain_to_config", 64'(state_o), 64'd0);

    vld_user = 4'b0001;
    start = 1'b1;
    #1;
    chk("config_no_ack", 64'(ack_user), 64'd0);
    tick();
    start = 1'b0;
    chk("restart_run", 64'(state_o), 64'd1);
    #1;
    chk("restart_ack", 64'(ack_user), 64'b0001);
    tick();
    chk("cfg_kept_addr_reset", 64'(dout_pkt), 64'(pk(5'd3, 4'd2, 7'd0, D0)));

    // oversized return on a full port must saturate
    vld_user = 4'b0000;
    upd_vld = 1'b1; upd_port = 4'd2; upd_amount = 8'd200;
    tick();
    upd_vld = 1'b0;

    // port1 alone: 128 packets, then starved; port 9 update must be ignored
    vld_user = 4'b0010;
    cfg_port = 4'd1;
    n = 0; aerr = 0;
    for (int c = 0; c < 138; c++) begin
      if (c == 132) begin
        upd_vld = 1'b1; upd_port = 4'd9; upd_amount = 8'd5;
      end else begin
        upd_vld = 1'b0;
      end
      #1;
      got = ack_user[1];
      tick();
      if (got) begin
        n++;
        if (dout_pkt[38:32] != 7'((n - 1) % 128) || dout_pkt[47:43] != 5'd5) aerr++;
      end
    end
    upd_vld = 1'b0;
    chk("port1_pkt_count", 64'(n), 64'd128);
    chk("port1_addr_seq", 64'(aerr), 64'd0);
    vld_user = 4'b0000;
    tick();
`ifdef LEAF_OUT_ARBITER_PERF_CNT_EN
    chk("stall_cnt_port1", 64'(dbg_stall_cnt), 64'd10);
`else
    chk("stall_cnt_absent", 64'(dbg_stall_cnt), 64'd0);
`endif

    vld_user = 4'b0010;
    upd_vld = 1'b1; upd_port = 4'd1; upd_amount = 8'd5;
    #1;
    chk("starved_ack", 64'(ack_user), 64'd0);
    tick();
    upd_amount = 8'd3;
    #1;
    chk("refill_ack", 64'(ack_user), 64'b0010);
    tick();
    upd_vld = 1'b0;
    chk("addr_wrap_pkt", 64'(dout_pkt), 64'(pk(5'd5, 4'd7, 7'd0, D1)));
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ack_user[1]) n++;
      tick();
    end
    chk("refill_count", 64'(n), 64'd7);

    vld_user = 4'b0100;
    n = 0;
    for (int c = 0; c < 132; c++) begin
      #1;
      if (ack_user[2]) n++;
      tick();
    end
    chk("port2_saturated_count", 64'(n), 64'd128);

    vld_user = 4'b1011;
    tick();
    tick();
    chk("pre_reset_valid", 64'(dout_pkt[48]), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pkt", 64'(dout_pkt), 64'd0);
    chk("async_reset_state", 64'(state_o), 64'd0);
    chk("async_reset_ack", 64'(ack_user), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
